// File: rtl/alsu_sequencer.sv
// Shares one ALSU between two command requesters: arbitrate, hold operands for the ALSU latency, return the result.
// Define ALSU_SEQ_ERR_CHK_EN to reject illegal commands with rsp_err instead of issuing them.
module alsu_sequencer #(
   parameter int ALSU_LAT  = 2,
   parameter int PRIO_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [15:0]       req0_cmd,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [15:0]       req1_cmd,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic signed [5:0] rsp_data,
   output logic              rsp_err,
   output logic signed [2:0] alsu_A,
   output logic signed [2:0] alsu_B,
   output logic [2:0]        alsu_opcode,
   output logic              alsu_cin,
   output logic              alsu_serial_in,
   output logic              alsu_red_op_A,
   output logic              alsu_red_op_B,
   output logic              alsu_bypass_A,
   output logic              alsu_bypass_B,
   output logic              alsu_direction,
   input  logic signed [5:0] alsu_out,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   state_t      state_next;
   logic [2:0]  cnt;
   logic        last_grant;
   logic [15:0] issued;
   logic        any_req;
   logic        grant;
   logic        grant_id;
   logic [15:0] grant_cmd;
   logic        cmd_bad;

   // last_grant==1 means requester 1 won last, so requester 0 takes the next tie.
   assign any_req   = req0_valid | req1_valid;
   assign grant_id  = (req0_valid && req1_valid) ? ((PRIO_MODE == 1) ? 1'b0 : ~last_grant)
                                                  : req1_valid;
   assign grant_cmd = grant_id ? req1_cmd : req0_cmd;

`ifdef ALSU_SEQ_ERR_CHK_EN
   assign cmd_bad = (grant_cmd[15:13] >= 3'd6) ||
                    ((grant_cmd[4] | grant_cmd[3]) && (grant_cmd[15:13] > 3'd1));
`else
   assign cmd_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               grant      = 1'b1;
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               state_next = cmd_bad ? RESP : WAIT;
            end
         end
         WAIT:    if (cnt == 3'd0) state_next = RESP;
         RESP:    if (rsp_ready)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= 3'd0;
         last_grant <= 1'b1;
         issued     <= 16'd0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= 6'sd0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  last_grant <= grant_id;
                  rsp_id     <= grant_id;
                  if (cmd_bad) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= 6'sd0;
                  end else begin
                     issued <= grant_cmd;
                     cnt    <= 3'(ALSU_LAT - 1);
                  end
               end
            end
            WAIT: begin
               if (cnt == 3'd0) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= alsu_out;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            RESP:    if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef ALSU_SEQ_ERR_CHK_EN
   logic err;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           err <= 1'b0;
      else if (state == IDLE && grant)    err <= cmd_bad;
      else if (state == RESP && rsp_ready) err <= 1'b0;
   end
   assign rsp_err = err;
`else
   assign rsp_err = 1'b0;
`endif

   // Operands stay on the ALSU after the response so shift/rotate inputs never glitch.
   assign alsu_opcode    = issued[15:13];
   assign alsu_A         = issued[12:10];
   assign alsu_B         = issued[9:7];
   assign alsu_cin       = issued[6];
   assign alsu_serial_in = issued[5];
   assign alsu_red_op_A  = issued[4];
   assign alsu_red_op_B  = issued[3];
   assign alsu_bypass_A  = issued[2];
   assign alsu_bypass_B  = issued[1];
   assign alsu_direction = issued[0];
   assign busy           = (state != IDLE);
endmodule

// File: tb/tb_alsu_sequencer.sv
// Bench for alsu_sequencer: a round-robin and a fixed-priority instance, each driving a stand-in ALSU,
// with random commands scored against a transaction-level model of arbitration and latency.
module tb_alsu_sequencer;
   localparam int ALSU_LAT = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [1:0]       req0_valid = '0;
   logic [1:0]       req1_valid = '0;
   logic [1:0]       req0_ready;
   logic [1:0]       req1_ready;
   logic [1:0][15:0] req0_cmd = '0;
   logic [1:0][15:0] req1_cmd = '0;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready = '0;
   logic [1:0]       rsp_id;
   logic [1:0]       rsp_err;
   logic [1:0]       busy;
   logic [1:0][5:0]  rsp_data;
   logic [1:0][5:0]  alsu_out = '0;
   logic [1:0][2:0]  alsu_A, alsu_B, alsu_opcode;
   logic [1:0]       alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
   logic [1:0]       alsu_bypass_A, alsu_bypass_B, alsu_direction;
   logic [1:0][15:0] issued;
   logic [1:0]       last_won;
   int               n_checks = 0;
   int               n_pass = 0;

   always #5 clk = ~clk;

   alsu_sequencer #(.ALSU_LAT(ALSU_LAT), .PRIO_MODE(0)) u_rr (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid[0]), .req0_ready(req0_ready[0]), .req0_cmd(req0_cmd[0]),
      .req1_valid(req1_valid[0]), .req1_ready(req1_ready[0]), .req1_cmd(req1_cmd[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_id(rsp_id[0]),
      .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
      .alsu_A(alsu_A[0]), .alsu_B(alsu_B[0]), .alsu_opcode(alsu_opcode[0]),
      .alsu_cin(alsu_cin[0]), .alsu_serial_in(alsu_serial_in[0]),
      .alsu_red_op_A(alsu_red_op_A[0]), .alsu_red_op_B(alsu_red_op_B[0]),
      .alsu_bypass_A(alsu_bypass_A[0]), .alsu_bypass_B(alsu_bypass_B[0]),
      .alsu_direction(alsu_direction[0]), .alsu_out(alsu_out[0]), .busy(busy[0])
   );

   alsu_sequencer #(.ALSU_LAT(ALSU_LAT), .PRIO_MODE(1)) u_fp (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid[1]), .req0_ready(req0_ready[1]), .req0_cmd(req0_cmd[1]),
      .req1_valid(req1_valid[1]), .req1_ready(req1_ready[1]), .req1_cmd(req1_cmd[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_id(rsp_id[1]),
      .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
      .alsu_A(alsu_A[1]), .alsu_B(alsu_B[1]), .alsu_opcode(alsu_opcode[1]),
      .alsu_cin(alsu_cin[1]), .alsu_serial_in(alsu_serial_in[1]),
      .alsu_red_op_A(alsu_red_op_A[1]), .alsu_red_op_B(alsu_red_op_B[1]),
      .alsu_bypass_A(alsu_bypass_A[1]), .alsu_bypass_B(alsu_bypass_B[1]),
      .alsu_direction(alsu_direction[1]), .alsu_out(alsu_out[1]), .busy(busy[1])
   );

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_pack
         assign issued[gi] = {alsu_opcode[gi], alsu_A[gi], alsu_B[gi], alsu_cin[gi],
                              alsu_serial_in[gi], alsu_red_op_A[gi], alsu_red_op_B[gi],
                              alsu_bypass_A[gi], alsu_bypass_B[gi], alsu_direction[gi]};
      end
   endgenerate

   // Stand-in ALSU: any deterministic function of the command, one register deep (ALSU_LAT=2).
   function automatic logic [5:0] alsu_f(input logic [15:0] c);
      logic [2:0] a, b;
      logic [5:0] ea, eb, r;
      a  = c[12:10];
      b  = c[9:7];
      ea = {{3{a[2]}}, a};
      eb = {{3{b[2]}}, b};
      case (c[15:13])
         3'd0:    r = c[4] ? {5'd0, &a} : (c[3] ? {5'd0, &b} : (ea & eb));
         3'd1:    r = c[4] ? {5'd0, ^a} : (c[3] ? {5'd0, ^b} : (ea ^ eb));
         3'd2:    r = ea * eb;
         3'd3:    r = ea + eb + {5'd0, c[6]};
         3'd4:    r = c[0] ? {a[1:0], b, c[5]} : {c[5], a, b[2:1]};
         3'd5:    r = c[0] ? {a[1:0], b, a[2]} : {b[0], a, b[2:1]};
         default: r = 6'd0;
      endcase
      if (c[2])      r = ea;
      else if (c[1]) r = eb;
      return r;
   endfunction

   function automatic logic cmd_illegal(input logic [15:0] c);
`ifdef ALSU_SEQ_ERR_CHK_EN
      return (c[15:13] >= 3'd6) || ((c[4] | c[3]) && (c[15:13] > 3'd1));
`else
      return c[15:13] > 3'd7;
`endif
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) alsu_out[d] <= alsu_f(issued[d]);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Entered just after a negedge with the DUT idle; returns just after the negedge following the handshake.
   task automatic txn(input int d, input logic v0, input logic v1, input logic [15:0] c0,
                      input logic [15:0] c1, input int hold, output int win);
      logic [15:0] wc, prev;
      logic [5:0]  ed;
      logic        ee;
      int          lat;
      req0_valid[d] = v0;
      req1_valid[d] = v1;
      req0_cmd[d]   = c0;
      req1_cmd[d]   = c1;
      #1;
      if (v0 && v1) win = (d == 1) ? 0 : (last_won[d] ? 0 : 1);
      else          win = v1 ? 1 : 0;
      last_won[d] = (win == 1);
      wc   = (win == 1) ? c1 : c0;
      ee   = cmd_illegal(wc);
      ed   = ee ? 6'd0 : alsu_f(wc);
      prev = issued[d];
      check("grant0", req0_ready[d], win == 0);
      check("grant1", req1_ready[d], win == 1);
      @(negedge clk);
      if (win == 0) req0_valid[d] = 1'b0;
      else          req1_valid[d] = 1'b0;
      check("issued", issued[d], ee ? prev : wc);
      lat = ee ? 1 : ALSU_LAT + 1;
      for (int k = 1; k < lat; k++) begin
         check("early_rsp", rsp_valid[d], 1'b0);
         check("busy_wait", busy[d], 1'b1);
         check("ready_wait", req0_ready[d] | req1_ready[d], 1'b0);
         rsp_ready[d] = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      rsp_ready[d] = 1'b0;
      check("rsp_valid", rsp_valid[d], 1'b1);
      check("rsp_id", rsp_id[d], win);
      check("rsp_data", rsp_data[d], ed);
      check("rsp_err", rsp_err[d], ee);
      check("ready_resp", req0_ready[d] | req1_ready[d], 1'b0);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("hold_valid", rsp_valid[d], 1'b1);
         check("hold_data", rsp_data[d], ed);
         check("ready_hold", req0_ready[d] | req1_ready[d], 1'b0);
      end
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      check("rsp_done", rsp_valid[d], 1'b0);
      check("busy_done", busy[d], 1'b0);
      $display("txn dut=%0d v=%0d%0d id=%0d data=%0h err=%0d hold=%0d",
               d, v0, v1, win, rsp_data[d], rsp_err[d], hold);
   endtask

   task automatic check_reset_state(input int d);
      check("rst_valid", rsp_valid[d], 1'b0);
      check("rst_busy", busy[d], 1'b0);
      check("rst_issued", issued[d], 16'd0);
      check("rst_data", rsp_data[d], 6'd0);
      check("rst_err", rsp_err[d], 1'b0);
      check("rst_id", rsp_id[d], 1'b0);
      check("rst_ready", req0_ready[d] | req1_ready[d], 1'b0);
   endtask

   task automatic burst(input int d, input int n, input bit both);
      logic [15:0] c0, c1;
      logic        p0, p1, v0, v1;
      logic [1:0]  r;
      int          win;
      p0 = 1'b0;
      p1 = 1'b0;
      c0 = '0;
      c1 = '0;
      for (int i = 0; i < n; i++) begin
         r = both ? 2'b11 : 2'($urandom_range(1, 3));
         if (!p0) c0 = 16'($urandom_range(0, 65535));
         if (!p1) c1 = 16'($urandom_range(0, 65535));
         v0 = p0 | r[0];
         v1 = p1 | r[1];
         txn(d, v0, v1, c0, c1, $urandom_range(0, 4), win);
         p0 = v0 && (win != 0);
         p1 = v1 && (win != 1);
      end
      req0_valid[d] = 1'b0;
      req1_valid[d] = 1'b0;
   endtask

   initial begin
      int win;
      last_won = 2'b11;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) check_reset_state(d);
      rst = 1'b1;
      @(negedge clk);

      txn(0, 1'b1, 1'b0, 16'h6D00, 16'h0000, 0, win);  // opcode 3, A=3, B=2 -> 5
      txn(0, 1'b0, 1'b1, 16'h0000, 16'h4A81, 4, win);  // backpressure for 4 cycles
      burst(0, 6, 1'b1);                               // continuous contention, round-robin
      burst(1, 3, 1'b1);                               // fixed priority, requester 0 always
      txn(1, 1'b0, 1'b1, 16'h0000, 16'h2C00, 1, win);
      burst(0, 24, 1'b0);
`ifdef ALSU_SEQ_ERR_CHK_EN
      txn(0, 1'b0, 1'b1, 16'h0000, 16'hC480, 2, win);  // opcode 6
      txn(0, 1'b1, 1'b0, 16'h4890, 16'h0000, 0, win);  // reduction with opcode 2
`endif

      // Abort a command in WAIT; no response may appear for it afterwards.
      req0_cmd[0]   = 16'h6D00;
      req0_valid[0] = 1'b1;
      #1;
      check("abort_grant", req0_ready[0], 1'b1);
      @(negedge clk);
      req0_valid[0] = 1'b0;
      check("abort_busy", busy[0], 1'b1);
      rst = 1'b0;
      #1;
      check_reset_state(0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      last_won = 2'b11;
      for (int k = 0; k < ALSU_LAT + 3; k++) begin
         @(negedge clk);
         check("abort_no_rsp", rsp_valid[0], 1'b0);
         check("abort_idle", busy[0], 1'b0);
      end
      burst(0, 4, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
